dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port C (core load/store path) and port D (DMA/debug loader).
- Valid/ready request handshake per port. One command is registered per grant and driven onto the memory's combinational-read / negedge-write interface for exactly one cycle.
- Arbitration is core-priority with a starvation counter that forces a D grant.

Parameters:
- ADDR_W, 32, address width of both ports and the memory address.
- DATA_W, 32, data width of the ports and the memory.
- STARVE_LIMIT, 4, consecutive C grants made while D is pending before D is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- c_valid / d_valid  in  1  request present on port C / D.
- c_ready / d_ready  out  1  request accepted this cycle when valid&&ready.
- c_addr / d_addr  in  ADDR_W  byte address.
- c_wdata / d_wdata  in  DATA_W  store data, low-aligned.
- c_we / d_we  in  1  1 = store, 0 = load.
- c_funct3 / d_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- c_rsp_valid / d_rsp_valid  out  1  one-cycle pulse: access completed.
- c_rsp_rdata / d_rsp_rdata  out  DATA_W  load data; 0 for stores.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory store data.
- mem_write / mem_read  out  1  memory strobes.
- mem_funct3  out  3  memory width code.
- mem_read_data  in  DATA_W  combinational memory read data.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All ready, rsp_valid, mem_write and mem_read = 0. mem_addr, mem_write_data, mem_funct3 and both rsp_rdata = 0. Starve count = 0, grant-owner reg = C.
- Reset asserted mid-ACCESS aborts the access. No rsp_valid is issued, and mem_write drops before the next negedge.
- FSM IDLE:
  - c_ready/d_ready are combinational, asserted only in IDLE, at most one high.
  - Winner rule: if d_valid and (!c_valid or starve==STARVE_LIMIT), D wins; else if c_valid, C wins.
  - On accept: latch addr/wdata/we/funct3/owner into the command reg and go to ACCESS.
  - Neither valid: stay IDLE, starve unchanged.
- FSM ACCESS (one cycle):
  - mem_* driven from the command reg; mem_read=!we, mem_write=we. The memory writes on the negedge inside this cycle.
  - At the posedge ending ACCESS: owner's rsp_rdata <= we ? 0 : mem_read_data; owner's rsp_valid <= 1 for one cycle; state <= IDLE.
- Strobes are 0 in IDLE. mem_addr/mem_write_data/mem_funct3 hold their last value.
- Latency: accept at posedge N, memory access in cycle N+1, rsp_valid high in cycle N+2. Peak throughput is one access per 2 cycles.
- rsp_valid of access k coincides with IDLE. A new accept in that same cycle is legal (back-to-back).
- Starve counter (4 bits):
  - Increments on each C grant while d_valid=1.
  - Clears on any D grant, or on any cycle in IDLE with d_valid=0.
  - Saturates at STARVE_LIMIT.
- Requester inputs are sampled only on accept; changes after accept have no effect.
- No response backpressure; requesters must consume rsp in the pulse cycle.
- Invalid funct3 (011, 110, 111) is passed through unchanged; the memory returns 0 for loads and ignores stores. rsp_valid still pulses.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_TRAP_EN.
- When defined:
  - Adds outputs c_rsp_err and d_rsp_err (1 bit), reset 0, pulsed alongside rsp_valid.
  - An access is misaligned if H/HU has addr[0]=1, or W has addr[1:0]!=0.
  - For a misaligned access: mem_write and mem_read stay 0 in ACCESS, rsp_rdata=0, err=1.
- When undefined: no err ports. Misaligned addresses pass through to memory, which aligns them down.

Decomposition:
- Shared package dmem_pkg:
  - funct3 width constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/ACCESS.
  - Owner encoding OWN_C=0 / OWN_D=1.
  - Command struct {addr, wdata, we, funct3, owner}.
- Sub-module dmem_arb_pick: combinational winner selection from c_valid, d_valid and starve count. Reused by later multi-port variants.

Test Plan:
- Reset: hold rst_n=0 three cycles with both valids high -> all readies/strobes 0 and both rsp_valid stay 0; first grant after release goes to C.
- C SW addr 0x20 wdata 0xDEADBEEF, then C LW 0x20 -> mem_write=1 exactly one cycle; LW c_rsp_rdata=0xDEADBEEF, two cycles after accept.
- D SB 0x31 data 0x80, then D LB 0x31 and LBU 0x31 -> d_rsp_rdata 0xFFFFFF80 then 0x00000080; c_rsp_valid never pulses.
- Both valid continuously, STARVE_LIMIT=4 -> grant order C,C,C,C,D,C,C,C,C,D; one-hot ready every IDLE cycle.
- Reset asserted in the ACCESS cycle of C SW 0x40 -> no rsp pulse; a later LW 0x40 returns the pre-store value.
- With DMEM_ARB_MISALIGN_TRAP_EN: C SH addr 0x41 -> mem_write stays 0, c_rsp_err=1, c_rsp_rdata=0. Without the macro, the store lands at 0x40.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter family.
// DMEM_ADDR_W/DMEM_DATA_W are the widest addr/data an arbiter instance may use.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int STARVE_W    = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
    typedef enum logic {OWN_C = 1'b0, OWN_D = 1'b1} owner_e;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic                   we;
        logic [2:0]             funct3;
        owner_e                 owner;
    } dmem_cmd_t;

    // Half-words must be 2-byte aligned, words 4-byte aligned; bytes never trap.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic r;
        case (f3)
            F3_H, F3_HU: r = a[0];
            F3_W:        r = (a != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way winner selection: core has priority unless the DMA port has been
// passed over STARVE_LIMIT times in a row.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                c_valid,
    input  logic                d_valid,
    input  logic [STARVE_W-1:0] starve,
    output logic                pick_c,
    output logic                pick_d
);

    always_comb begin
        pick_d = d_valid && (!c_valid || (starve == STARVE_W'(STARVE_LIMIT)));
        pick_c = c_valid && !pick_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between core (C) and DMA/debug (D) requesters.
// Optional DMEM_ARB_MISALIGN_TRAP_EN adds c_rsp_err/d_rsp_err and suppresses misaligned accesses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              c_we,
    input  logic [2:0]        c_funct3,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rsp_rdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    output logic              c_rsp_err,
    output logic              d_rsp_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e              state;
    dmem_cmd_t           cmd;
    dmem_cmd_t           nxt;
    logic [STARVE_W-1:0] starve;
    logic                pick_c, pick_d;
    logic                misal;
    logic                wr_q, rd_q, trap_q;
    logic [DATA_W-1:0]   rsp_data;

    dmem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .c_valid (c_valid),
        .d_valid (d_valid),
        .starve  (starve),
        .pick_c  (pick_c),
        .pick_d  (pick_d)
    );

    assign c_ready = rst_n && (state == IDLE) && pick_c;
    assign d_ready = rst_n && (state == IDLE) && pick_d;

    always_comb begin
        nxt = '0;
        if (pick_d) begin
            nxt.addr   = DMEM_ADDR_W'(d_addr);
            nxt.wdata  = DMEM_DATA_W'(d_wdata);
            nxt.we     = d_we;
            nxt.funct3 = d_funct3;
            nxt.owner  = OWN_D;
        end else begin
            nxt.addr   = DMEM_ADDR_W'(c_addr);
            nxt.wdata  = DMEM_DATA_W'(c_wdata);
            nxt.we     = c_we;
            nxt.funct3 = c_funct3;
            nxt.owner  = OWN_C;
        end
    end

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    assign misal = misaligned(nxt.funct3, nxt.addr[1:0]);
`else
    assign misal = 1'b0;
`endif

    // Strobes are gated by rst_n so a reset raised inside ACCESS kills the
    // negedge write before the synchronous reset itself takes effect.
    assign mem_write      = wr_q && rst_n;
    assign mem_read       = rd_q && rst_n;
    assign mem_addr       = cmd.addr[ADDR_W-1:0];
    assign mem_write_data = cmd.wdata[DATA_W-1:0];
    assign mem_funct3     = cmd.funct3;
    assign rsp_data       = (cmd.we || trap_q) ? '0 : mem_read_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd         <= '0;
            starve      <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            trap_q      <= 1'b0;
            c_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            c_rsp_rdata <= '0;
            d_rsp_rdata <= '0;
        end else begin
            c_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_ready || d_ready) begin
                        cmd    <= nxt;
                        trap_q <= misal;
                        wr_q   <= nxt.we && !misal;
                        rd_q   <= !nxt.we && !misal;
                        state  <= ACCESS;
                    end
                    if (d_ready)
                        starve <= '0;
                    else if (c_ready && d_valid) begin
                        if (starve < STARVE_W'(STARVE_LIMIT))
                            starve <= starve + 1'b1;
                    end else if (!d_valid)
                        starve <= '0;
                end
                ACCESS: begin
                    wr_q  <= 1'b0;
                    rd_q  <= 1'b0;
                    state <= IDLE;
                    if (cmd.owner == OWN_D) begin
                        d_rsp_valid <= 1'b1;
                        d_rsp_rdata <= rsp_data;
                    end else begin
                        c_rsp_valid <= 1'b1;
                        c_rsp_rdata <= rsp_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_rsp_err <= 1'b0;
            d_rsp_err <= 1'b0;
        end else begin
            c_rsp_err <= (state == ACCESS) && (cmd.owner == OWN_C) && trap_q;
            d_rsp_err <= (state == ACCESS) && (cmd.owner == OWN_D) && trap_q;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed memory model, directed vector table,
// plus hand sequences for reset, arbitration fairness and aborted access.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_valid, c_ready, c_we, d_valid, d_ready, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [2:0]  c_funct3, d_funct3;
    logic        c_rsp_valid, d_rsp_valid;
    logic [31:0] c_rsp_rdata, d_rsp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;
    logic [2:0]  mem_funct3;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    logic        c_rsp_err, d_rsp_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_we(c_we), .c_funct3(c_funct3),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_we(d_we), .d_funct3(d_funct3),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        .c_rsp_err(c_rsp_err), .d_rsp_err(d_rsp_err),
`endif
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_funct3(mem_funct3),
        .mem_read_data(mem_read_data)
    );

    // Memory model: 256 bytes, little endian, aligns misaligned H/W down.
    logic [7:0] mem [0:255];

    always_comb begin
        int ba, ha, wa;
        ba = int'(mem_addr[7:0]);
        ha = ba & 254;
        wa = ba & 252;
        case (mem_funct3)
            F3_B:    mem_read_data = {{24{mem[ba][7]}}, mem[ba]};
            F3_BU:   mem_read_data = {24'h0, mem[ba]};
            F3_H:    mem_read_data = {{16{mem[ha+1][7]}}, mem[ha+1], mem[ha]};
            F3_HU:   mem_read_data = {16'h0, mem[ha+1], mem[ha]};
            F3_W:    mem_read_data = {mem[wa+3], mem[wa+2], mem[wa+1], mem[wa]};
            default: mem_read_data = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        int ba, ha, wa;
        ba = int'(mem_addr[7:0]);
        ha = ba & 254;
        wa = ba & 252;
        if (mem_write) begin
            case (mem_funct3)
                F3_B: mem[ba] <= mem_write_data[7:0];
                F3_H: begin
                    mem[ha]   <= mem_write_data[7:0];
                    mem[ha+1] <= mem_write_data[15:8];
                end
                F3_W: begin
                    mem[wa]   <= mem_write_data[7:0];
                    mem[wa+1] <= mem_write_data[15:8];
                    mem[wa+2] <= mem_write_data[23:16];
                    mem[wa+3] <= mem_write_data[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        port;   // 0 = C, 1 = D
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk); #1;
        c_valid = 1'b0;
        d_valid = 1'b0;
        if (v.port) begin
            d_valid = 1'b1; d_we = v.we; d_funct3 = v.f3; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            c_valid = 1'b1; c_we = v.we; c_funct3 = v.f3; c_addr = v.addr; c_wdata = v.wdata;
        end
        #1;
        chk({tag, "_ready"}, {30'h0, c_ready, d_ready}, v.port ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        c_valid = 1'b0;
        d_valid = 1'b0;
        chk({tag, "_mem_write"}, {31'h0, mem_write}, {31'h0, v.we && !v.exp_err});
        chk({tag, "_mem_read"}, {31'h0, mem_read}, {31'h0, !v.we && !v.exp_err});
        chk({tag, "_mem_addr"}, mem_addr, v.addr);
        chk({tag, "_mem_f3"}, {29'h0, mem_funct3}, {29'h0, v.f3});
        chk({tag, "_mem_wdata"}, mem_write_data, v.wdata);
        @(posedge clk); #1;
        chk({tag, "_rsp_valid"}, {30'h0, c_rsp_valid, d_rsp_valid}, v.port ? 32'd1 : 32'd2);
        chk({tag, "_rdata"}, v.port ? d_rsp_rdata : c_rsp_rdata, v.exp_rdata);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        chk({tag, "_err"}, {30'h0, c_rsp_err, d_rsp_err},
            v.exp_err ? (v.port ? 32'd1 : 32'd2) : 32'd0);
`endif
        @(posedge clk); #1;
        chk({tag, "_rsp_drop"}, {30'h0, c_rsp_valid, d_rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [9:0] exp_g;
        int gi;
        vec_t pre;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //            port we   f3     addr      wdata         exp_rdata     err
        tbl[0]  = '{1'b0, 1'b1, F3_W,  32'h20, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b0, F3_W,  32'h20, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, F3_B,  32'h31, 32'h00000080, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, F3_B,  32'h31, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, F3_BU, 32'h31, 32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, F3_H,  32'h22, 32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, F3_HU, 32'h22, 32'h0,        32'h0000DEAD, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, F3_H,  32'h24, 32'h1234ABCD, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, F3_W,  32'h24, 32'h0,        32'h0000ABCD, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 3'b011, 32'h20, 32'h0,       32'h0,        1'b0};
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        tbl[10] = '{1'b0, 1'b1, F3_H,  32'h41, 32'h00005555, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 1'b0, F3_W,  32'h40, 32'h0,        32'h11223344, 1'b0};
`else
        tbl[10] = '{1'b0, 1'b1, F3_H,  32'h41, 32'h00005555, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b0, F3_W,  32'h40, 32'h0,        32'h11225555, 1'b0};
`endif

        // Reset held three cycles with both requesters asserting.
        rst_n = 1'b0;
        c_valid = 1'b1; c_we = 1'b0; c_funct3 = F3_W; c_addr = 32'h20; c_wdata = 32'h0;
        d_valid = 1'b1; d_we = 1'b0; d_funct3 = F3_W; d_addr = 32'h24; d_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ready", {30'h0, c_ready, d_ready}, 32'd0);
            chk("rst_strobe", {30'h0, mem_write, mem_read}, 32'd0);
            chk("rst_rsp", {30'h0, c_rsp_valid, d_rsp_valid}, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_rdata", c_rsp_rdata | d_rsp_rdata, 32'd0);
        end
        rst_n = 1'b1;
        #1;

        // Both valid continuously: four C grants then a forced D grant.
        exp_g = 10'b10_0001_0000;
        gi = 0;
        for (int cy = 0; cy < 20; cy++) begin
            if (cy % 2 == 0) begin
                chk("arb_onehot", {31'h0, c_ready ^ d_ready}, 32'd1);
                chk($sformatf("arb_grant%0d", gi), {31'h0, d_ready}, {31'h0, exp_g[gi]});
                gi++;
            end else begin
                chk("arb_access_noready", {30'h0, c_ready, d_ready}, 32'd0);
            end
            @(posedge clk); #1;
        end
        c_valid = 1'b0;
        d_valid = 1'b0;
        chk("arb_last_rsp", {30'h0, c_rsp_valid, d_rsp_valid}, 32'd1);
        @(posedge clk); #1;

        // Reset in the ACCESS cycle of a store aborts it.
        pre = '{1'b0, 1'b1, F3_W, 32'h40, 32'h11223344, 32'h0, 1'b0};
        run_vec(pre, "pre_sw40");
        @(posedge clk); #1;
        c_valid = 1'b1; c_we = 1'b1; c_funct3 = F3_W; c_addr = 32'h40; c_wdata = 32'hCAFEF00D;
        #1;
        chk("abort_ready", {31'h0, c_ready}, 32'd1);
        @(posedge clk); #1;
        c_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", {31'h0, mem_write}, 32'd0);
        @(posedge clk); #1;
        chk("abort_rsp0", {30'h0, c_rsp_valid, d_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rsp1", {30'h0, c_rsp_valid, d_rsp_valid}, 32'd0);
        pre = '{1'b0, 1'b0, F3_W, 32'h40, 32'h0, 32'h11223344, 1'b0};
        run_vec(pre, "post_lw40");

        for (int i = 0; i < 12; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
